// File: rtl/pru_pkg.sv
// Shared types and constants for the PRU command scheduler.
package pru_pkg;

   localparam int unsigned CMD_W        = 64;
   localparam int unsigned PP_START_BIT = 11;
   localparam int unsigned PP_SHAPE_LSB = 9;
   localparam int unsigned PP_COLOR_LSB = 0;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SEND_W0,
      ST_SEND_W1,
      ST_WAIT_DONE
   } sched_state_t;

endpackage

// File: rtl/pru_cmd_scheduler_if.sv
// Bus bundle between the two command sources, the preprocessor and the scheduler.
interface pru_cmd_scheduler_if;
   import pru_pkg::*;

   logic             req0_valid;
   logic [CMD_W-1:0] req0_cmd;
   logic             req0_ready;
   logic             req1_valid;
   logic [CMD_W-1:0] req1_cmd;
   logic             req1_ready;
   logic             pp_write;
   logic [31:0]      pp_data;
   logic             pp_ack;
   logic             pru_done;
   logic             busy;
   logic             grant_id;
   logic             timeout_err;
   logic             err_clear;

   modport slave (
      input  req0_valid, req0_cmd, req1_valid, req1_cmd, pp_ack, pru_done, err_clear,
      output req0_ready, req1_ready, pp_write, pp_data, busy, grant_id, timeout_err
   );

   modport master (
      output req0_valid, req0_cmd, req1_valid, req1_cmd, pp_ack, pru_done, err_clear,
      input  req0_ready, req1_ready, pp_write, pp_data, busy, grant_id, timeout_err
   );

endinterface

// File: rtl/pru_rr_arb2.sv
// Combinational 2-way round-robin arbiter; the last-grant history lives in the parent.
module pru_rr_arb2 (
   input  logic [1:0] req,
   input  logic       last,
   input  logic       en,
   output logic [1:0] gnt,
   output logic       gnt_id
);

   always_comb begin
      gnt_id = (&req) ? ~last : req[1];
      gnt    = '0;
      if (en && (|req)) begin
         gnt = gnt_id ? 2'b10 : 2'b01;
      end
   end

endmodule

// File: rtl/pru_cmd_scheduler.sv
// Round-robin scheduler that serialises 64-bit draw commands into the preprocessor's
// two-word write/ack protocol and waits for PRU completion after start commands.
module pru_cmd_scheduler
   import pru_pkg::*;
#(
   parameter int unsigned DONE_TIMEOUT = 1_000_000
) (
   input  logic              clk,
   input  logic              rst,
   pru_cmd_scheduler_if.slave bus
);

   localparam int unsigned           TIMER_W    = (DONE_TIMEOUT == 0) ? 1 : $clog2(DONE_TIMEOUT + 1);
   localparam logic [TIMER_W-1:0]    TIMER_LAST = TIMER_W'(DONE_TIMEOUT - 1);
   localparam logic [TIMER_W-1:0]    TIMER_MAX  = '1;

   sched_state_t       r_state;
   sched_state_t       w_state_nxt;
   logic [CMD_W-1:0]   r_cmd;
   logic               r_grant_id;
   logic               r_last_grant;
   logic               r_timeout_err;
   logic [TIMER_W-1:0] r_timer;
   logic [TIMER_W-1:0] w_timer_nxt;
   logic [1:0]         w_gnt;
   logic               w_gnt_id;
   logic               w_arb_en;
   logic               w_take;
   logic               w_set_err;
   logic               w_pp_write;
   logic [31:0]        w_pp_data;

   // Ready is masked while rst is high so no grant is offered during reset.
   assign w_arb_en = (r_state == ST_IDLE) && !rst;

   pru_rr_arb2 u_arb (
      .req    ({bus.req1_valid, bus.req0_valid}),
      .last   (r_last_grant),
      .en     (w_arb_en),
      .gnt    (w_gnt),
      .gnt_id (w_gnt_id)
   );

   assign w_take = |w_gnt;

   always_comb begin
      w_state_nxt = r_state;
      w_timer_nxt = r_timer;
      w_set_err   = 1'b0;
      w_pp_write  = 1'b0;
      w_pp_data   = '0;
      case (r_state)
         ST_IDLE: begin
            if (w_take) w_state_nxt = ST_SEND_W0;
         end
         ST_SEND_W0: begin
            w_pp_write = 1'b1;
            w_pp_data  = r_cmd[31:0];
            if (bus.pp_ack) w_state_nxt = ST_SEND_W1;
         end
         ST_SEND_W1: begin
            w_pp_write = 1'b1;
            w_pp_data  = r_cmd[CMD_W-1:32];
            if (bus.pp_ack) begin
               if (r_cmd[32 + PP_START_BIT]) begin
                  w_state_nxt = ST_WAIT_DONE;
                  w_timer_nxt = '0;
               end else begin
                  w_state_nxt = ST_IDLE;
               end
            end
         end
         ST_WAIT_DONE: begin
            // Completion takes precedence over a timeout landing in the same cycle.
            if (bus.pru_done) begin
               w_state_nxt = ST_IDLE;
            end else if ((DONE_TIMEOUT != 0) && (r_timer == TIMER_LAST)) begin
               w_set_err   = 1'b1;
               w_state_nxt = ST_IDLE;
            end else if (r_timer != TIMER_MAX) begin
               w_timer_nxt = r_timer + 1'b1;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state       <= ST_IDLE;
         r_cmd         <= '0;
         r_grant_id    <= 1'b0;
         r_last_grant  <= 1'b1;
         r_timeout_err <= 1'b0;
         r_timer       <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_timer <= w_timer_nxt;
         if (w_take) begin
            r_cmd        <= w_gnt_id ? bus.req1_cmd : bus.req0_cmd;
            r_grant_id   <= w_gnt_id;
            r_last_grant <= w_gnt_id;
         end
         if (w_set_err) begin
            r_timeout_err <= 1'b1;
         end else if (bus.err_clear) begin
            r_timeout_err <= 1'b0;
         end
      end
   end

   assign bus.req0_ready  = w_gnt[0];
   assign bus.req1_ready  = w_gnt[1];
   assign bus.pp_write    = w_pp_write;
   assign bus.pp_data     = w_pp_data;
   assign bus.busy        = (r_state != ST_IDLE);
   assign bus.grant_id    = r_grant_id;
   assign bus.timeout_err = r_timeout_err;

endmodule

// File: tb/tb_pru_cmd_scheduler.sv
// Directed self-checking bench for pru_cmd_scheduler (default timeout and an 8-cycle timeout instance).
module tb_pru_cmd_scheduler;
   import pru_pkg::*;

   localparam logic [63:0] CMD_S = 64'hCAFE_0A05_1234_5678;
   localparam logic [63:0] CMD_N = 64'h0000_0205_AAAA_5555;
   localparam logic [63:0] CMD_D = 64'h7654_0300_89AB_CDEF;
   localparam logic [63:0] C0A   = 64'h0101_0001_0A0A_0A0A;
   localparam logic [63:0] C1A   = 64'h0202_0002_1B1B_1B1B;
   localparam logic [63:0] C0B   = 64'h0303_0003_2C2C_2C2C;
   localparam logic [63:0] C1B   = 64'h0404_0004_3D3D_3D3D;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic ack_en;
   int   checks   = 0;
   int   failures = 0;
   int   xfer_a   = 0;
   int   n0;
   logic [63:0] rr_cmd [4];
   logic        rr_id  [4];

   always #5 clk = ~clk;

   pru_cmd_scheduler_if ifa ();
   pru_cmd_scheduler_if ifb ();

   assign ifa.pp_ack = ifa.pp_write & ack_en;
   assign ifb.pp_ack = ifb.pp_write;

   pru_cmd_scheduler dut_a (
      .clk (clk),
      .rst (rst),
      .bus (ifa.slave)
   );

   pru_cmd_scheduler #(.DONE_TIMEOUT(8)) dut_t (
      .clk (clk),
      .rst (rst),
      .bus (ifb.slave)
   );

   always @(posedge clk) begin
      if (!rst && ifa.pp_write && ifa.pp_ack) xfer_a++;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic settle();
      #1;
   endtask

   initial begin
      ifa.req0_valid = 1'b0; ifa.req0_cmd = '0; ifa.req1_valid = 1'b0; ifa.req1_cmd = '0;
      ifa.pru_done   = 1'b0; ifa.err_clear = 1'b0;
      ifb.req0_valid = 1'b0; ifb.req0_cmd = '0; ifb.req1_valid = 1'b0; ifb.req1_cmd = '0;
      ifb.pru_done   = 1'b0; ifb.err_clear = 1'b0;
      ack_en = 1'b1;
      rst    = 1'b1;
      ifa.req0_valid = 1'b1; ifa.req0_cmd = C0A;
      ifa.req1_valid = 1'b1; ifa.req1_cmd = C1A;
      tick(2);

      chk("rst_busy",     ifa.busy,        0);
      chk("rst_pp_write", ifa.pp_write,    0);
      chk("rst_pp_data",  ifa.pp_data,     0);
      chk("rst_ready0",   ifa.req0_ready,  0);
      chk("rst_ready1",   ifa.req1_ready,  0);
      chk("rst_grant_id", ifa.grant_id,    0);
      chk("rst_tmo_err",  ifa.timeout_err, 0);

      // Both sources valid for four commands: expect 0,1,0,1.
      rr_cmd[0] = C0A; rr_cmd[1] = C1A; rr_cmd[2] = C0B; rr_cmd[3] = C1B;
      rr_id[0]  = 0;   rr_id[1]  = 1;   rr_id[2]  = 0;   rr_id[3]  = 1;
      rst = 1'b0;
      settle();
      for (int r = 0; r < 4; r++) begin
         chk("rr_ready0", ifa.req0_ready, (rr_id[r] == 1'b0) ? 1 : 0);
         chk("rr_ready1", ifa.req1_ready, (rr_id[r] == 1'b1) ? 1 : 0);
         chk("rr_idle",   ifa.busy,       0);
         tick();
         if (rr_id[r] == 1'b0) begin
            if (r == 0) ifa.req0_cmd = C0B; else ifa.req0_valid = 1'b0;
         end else begin
            if (r == 1) ifa.req1_cmd = C1B; else ifa.req1_valid = 1'b0;
         end
         settle();
         chk("rr_grant_id",  ifa.grant_id, rr_id[r]);
         chk("rr_w0_write",  ifa.pp_write, 1);
         chk("rr_w0_data",   ifa.pp_data,  rr_cmd[r][31:0]);
         chk("rr_w0_noready", ifa.req0_ready | ifa.req1_ready, 0);
         tick();
         chk("rr_w1_data",   ifa.pp_data,  rr_cmd[r][63:32]);
         chk("rr_w1_noready", ifa.req0_ready | ifa.req1_ready, 0);
         tick();
      end
      chk("rr_end_idle", ifa.busy, 0);

      // Single start command on req0, done pulse ten cycles after WAIT_DONE entry.
      ifa.req0_cmd = CMD_S; ifa.req0_valid = 1'b1;
      settle();
      chk("s_ready0", ifa.req0_ready, 1);
      n0 = xfer_a;
      tick();
      ifa.req0_valid = 1'b0;
      settle();
      chk("s_ready0_drop", ifa.req0_ready, 0);
      chk("s_w0_write",    ifa.pp_write,   1);
      chk("s_w0_data",     ifa.pp_data,    CMD_S[31:0]);
      chk("s_busy",        ifa.busy,       1);
      chk("s_grant_id",    ifa.grant_id,   0);
      tick();
      chk("s_w1_data",     ifa.pp_data,    CMD_S[63:32]);
      tick();
      chk("s_wait_write",  ifa.pp_write,   0);
      chk("s_wait_data",   ifa.pp_data,    0);
      chk("s_wait_busy",   ifa.busy,       1);
      tick(9);
      chk("s_wait_busy9",  ifa.busy,       1);
      chk("s_wait_ready",  ifa.req0_ready, 0);
      ifa.pru_done = 1'b1;
      tick();
      ifa.pru_done = 1'b0;
      settle();
      chk("s_done_idle",   ifa.busy,       0);
      chk("s_xfers",       xfer_a - n0,    2);

      // Non-start command returns to IDLE three cycles after grant.
      ifa.req0_cmd = CMD_N; ifa.req0_valid = 1'b1;
      settle();
      chk("n_ready0", ifa.req0_ready, 1);
      tick();
      ifa.req0_valid = 1'b0;
      tick();
      chk("n_w1_data", ifa.pp_data, CMD_N[63:32]);
      tick();
      chk("n_idle_n3",  ifa.busy,     0);
      chk("n_no_write", ifa.pp_write, 0);
      ifa.pru_done = 1'b1;
      tick();
      ifa.pru_done = 1'b0;
      settle();
      chk("n_done_ignored_busy", ifa.busy,        0);
      chk("n_done_ignored_err",  ifa.timeout_err, 0);

      // pp_ack withheld five cycles in SEND_W0.
      ack_en = 1'b0;
      ifa.req0_cmd = CMD_D; ifa.req0_valid = 1'b1;
      settle();
      n0 = xfer_a;
      tick();
      ifa.req0_valid = 1'b0;
      settle();
      for (int k = 0; k < 6; k++) begin
         if (k == 5) begin
            ack_en = 1'b1;
            settle();
         end
         chk("h_w0_write", ifa.pp_write, 1);
         chk("h_w0_data",  ifa.pp_data,  CMD_D[31:0]);
         tick();
      end
      chk("h_one_w0",  xfer_a - n0, 1);
      chk("h_w1_data", ifa.pp_data, CMD_D[63:32]);
      tick();
      chk("h_two_xfers", xfer_a - n0, 2);
      chk("h_idle",      ifa.busy,    0);

      // Timeout instance: eight WAIT_DONE cycles without done.
      ifb.req0_cmd = CMD_S; ifb.req0_valid = 1'b1;
      settle();
      tick();
      ifb.req0_valid = 1'b0;
      tick(2);
      chk("t_wait_busy",  ifb.busy,        1);
      chk("t_wait_err0",  ifb.timeout_err, 0);
      tick(7);
      chk("t_cyc8_busy",  ifb.busy,        1);
      chk("t_cyc8_err0",  ifb.timeout_err, 0);
      tick();
      chk("t_err_set",    ifb.timeout_err, 1);
      chk("t_err_idle",   ifb.busy,        0);
      ifb.req0_cmd = CMD_N; ifb.req0_valid = 1'b1;
      settle();
      chk("t_next_ready", ifb.req0_ready,  1);
      tick();
      ifb.req0_valid = 1'b0;
      settle();
      chk("t_next_busy",  ifb.busy,        1);
      chk("t_err_sticky", ifb.timeout_err, 1);
      tick(2);
      chk("t_next_idle",  ifb.busy,        0);
      ifb.err_clear = 1'b1;
      tick();
      ifb.err_clear = 1'b0;
      settle();
      chk("t_err_cleared", ifb.timeout_err, 0);

      // Done on the final timeout cycle wins.
      ifb.req0_cmd = CMD_S; ifb.req0_valid = 1'b1;
      settle();
      tick();
      ifb.req0_valid = 1'b0;
      tick(2);
      tick(7);
      ifb.pru_done = 1'b1;
      tick();
      ifb.pru_done = 1'b0;
      settle();
      chk("d_wins_idle", ifb.busy,        0);
      chk("d_wins_err",  ifb.timeout_err, 0);

      // Timeout set beats a simultaneous err_clear.
      ifb.req0_valid = 1'b1;
      settle();
      tick();
      ifb.req0_valid = 1'b0;
      tick(2);
      tick(7);
      ifb.err_clear = 1'b1;
      tick();
      ifb.err_clear = 1'b0;
      settle();
      chk("set_over_clear", ifb.timeout_err, 1);

      // Reset during SEND_W1.
      ifa.req1_cmd = CMD_S; ifa.req1_valid = 1'b1;
      settle();
      tick();
      ifa.req1_valid = 1'b0;
      tick();
      chk("r_w1_write",    ifa.pp_write, 1);
      chk("r_w1_grant_id", ifa.grant_id, 1);
      ifa.req0_cmd = C0A; ifa.req0_valid = 1'b1;
      rst = 1'b1;
      settle();
      chk("r_pp_write", ifa.pp_write,   0);
      chk("r_pp_data",  ifa.pp_data,    0);
      chk("r_busy",     ifa.busy,       0);
      chk("r_grant_id", ifa.grant_id,   0);
      chk("r_ready0",   ifa.req0_ready, 0);
      tick();
      rst = 1'b0;
      ifa.req1_cmd = C1A; ifa.req1_valid = 1'b1;
      settle();
      chk("r_first_ready0", ifa.req0_ready, 1);
      chk("r_first_ready1", ifa.req1_ready, 0);
      tick();
      chk("r_first_gid",  ifa.grant_id, 0);
      chk("r_first_data", ifa.pp_data,  C0A[31:0]);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
